// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode constants, control FSM states and the
// encodings of the PC, writeback and ALU select fields.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0, ALU_FUNC = 2'd1, ALU_CMP = 2'd2
    } alu_mode_e;

    typedef enum logic [3:0] {
        C_REG, C_IMM, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_FENCE, C_SYSTEM, C_ILLEGAL
    } cls_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle FSM and the datapath/memory port.
interface mc_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_mode;
    logic        retire;
    logic        halted;
    logic        trap_illegal;

    modport master (
        input  instr, mem_ready, branch_taken,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, rf_we,
               wb_sel, alu_a_sel, alu_b_sel, alu_mode, retire, halted,
               trap_illegal
    );

    modport slave (
        output instr, mem_ready, branch_taken,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, rf_we,
               wb_sel, alu_a_sel, alu_b_sel, alu_mode, retire, halted,
               trap_illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; only ECALL/EBREAK are accepted from the
// SYSTEM space, everything else there is illegal.
module ctrl_decode
    import rv32_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [11:0] funct12,
    output cls_e        cls,
    output logic        illegal
);
    always_comb begin
        cls = C_ILLEGAL;
        case (opcode)
            OP_REG:    cls = C_REG;
            OP_IMM:    cls = C_IMM;
            OP_LUI:    cls = C_LUI;
            OP_AUIPC:  cls = C_AUIPC;
            OP_LOAD:   cls = C_LOAD;
            OP_STORE:  cls = C_STORE;
            OP_BRANCH: cls = C_BRANCH;
            OP_JAL:    cls = C_JAL;
            OP_JALR:   cls = C_JALR;
            OP_FENCE:  cls = C_FENCE;
            OP_SYSTEM: if (funct3 == 3'd0 && funct12[11:1] == 11'd0) cls = C_SYSTEM;
            default:   cls = C_ILLEGAL;
        endcase
        illegal = (cls == C_ILLEGAL);
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port; outputs are a combinational decode of state and IR.
module mc_ctrl
    import rv32_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    cls_e      cls;
    logic      illegal;
    state_e    state, state_nxt;
    logic      trap_q, trap_nxt;
    logic      a_ctl, b_ctl;
    alu_mode_e mode_ctl;

    ctrl_decode u_dec (
        .opcode  (bus.instr[6:0]),
        .funct3  (bus.instr[14:12]),
        .funct12 (bus.instr[31:20]),
        .cls     (cls),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            trap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            trap_q <= trap_nxt;
        end
    end

    // ALU setup per class; reused unchanged in EXEC, MEM and WB
    always_comb begin
        a_ctl    = 1'b0;
        b_ctl    = 1'b0;
        mode_ctl = ALU_ADD;
        case (cls)
            C_REG:    mode_ctl = ALU_FUNC;
            C_IMM:    begin mode_ctl = ALU_FUNC; b_ctl = 1'b1; end
            C_AUIPC:  begin a_ctl = 1'b1; b_ctl = 1'b1; end
            C_LOAD, C_STORE, C_JALR: b_ctl = 1'b1;
            C_BRANCH: mode_ctl = ALU_CMP;
            default:  ;
        endcase
    end

    always_comb begin
        state_nxt        = state;
        trap_nxt         = trap_q;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = PC_PLUS4;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = WB_ALU;
        bus.alu_a_sel    = 1'b0;
        bus.alu_b_sel    = 1'b0;
        bus.alu_mode     = ALU_ADD;
        bus.retire       = 1'b0;
        bus.halted       = (state == S_HALT);
        bus.trap_illegal = trap_q;

        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                bus.alu_a_sel = a_ctl;
                bus.alu_b_sel = b_ctl;
                bus.alu_mode  = mode_ctl;
                if (illegal) begin
                    state_nxt = S_HALT;
                    trap_nxt  = 1'b1;
                end else begin
                    case (cls)
                        C_LOAD, C_STORE: state_nxt = S_MEM;
                        C_BRANCH: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = bus.branch_taken ? PC_IMM : PC_PLUS4;
                            bus.retire = 1'b1;
                            state_nxt  = S_FETCH;
                        end
                        C_JAL, C_JALR: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = (cls == C_JAL) ? PC_IMM : PC_ALU;
                            bus.rf_we  = 1'b1;
                            bus.wb_sel = WB_PC4;
                            bus.retire = 1'b1;
                            state_nxt  = S_FETCH;
                        end
                        C_FENCE: begin
                            bus.pc_we  = 1'b1;
                            bus.retire = 1'b1;
                            state_nxt  = S_FETCH;
                        end
                        // ECALL/EBREAK retire without moving the PC
                        C_SYSTEM: begin
                            bus.retire = 1'b1;
                            state_nxt  = S_HALT;
                            trap_nxt   = 1'b0;
                        end
                        default: state_nxt = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (cls == C_STORE);
                bus.alu_a_sel    = a_ctl;
                bus.alu_b_sel    = b_ctl;
                bus.alu_mode     = mode_ctl;
                if (bus.mem_ready) begin
                    if (cls == C_STORE) begin
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        state_nxt  = S_WB;
                    end
                end
            end
            S_WB: begin
                bus.alu_a_sel = a_ctl;
                bus.alu_b_sel = b_ctl;
                bus.alu_mode  = mode_ctl;
                bus.rf_we     = 1'b1;
                bus.pc_we     = 1'b1;
                bus.retire    = 1'b1;
                bus.wb_sel    = (cls == C_LOAD) ? WB_MEM :
                                (cls == C_LUI)  ? WB_IMM : WB_ALU;
                state_nxt     = S_FETCH;
            end
            S_HALT:  ;
            default: state_nxt = S_FETCH;
        endcase

        // reset cycle: abandon any request and keep every enable low
        if (rst) begin
            bus.mem_req      = 1'b0;
            bus.mem_we       = 1'b0;
            bus.mem_addr_sel = 1'b0;
            bus.ir_we        = 1'b0;
            bus.pc_we        = 1'b0;
            bus.pc_src       = PC_PLUS4;
            bus.rf_we        = 1'b0;
            bus.wb_sel       = WB_ALU;
            bus.alu_a_sel    = 1'b0;
            bus.alu_b_sel    = 1'b0;
            bus.alu_mode     = ALU_ADD;
            bus.retire       = 1'b0;
            bus.halted       = 1'b0;
            bus.trap_illegal = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instructions push expected retire /
// halt records, a monitor pops and compares them as the DUT produces them.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mc_ctrl_if bus ();

    mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit         halt;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       b_sel;
        logic       trap;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   fwait = 0;
    int   mwait = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ret(input logic pw, input logic [1:0] ps, input logic rf,
                                 input logic [1:0] wb, input logic bs, input int cyc);
        exp_t e;
        e.halt = 0; e.pc_we = pw; e.pc_src = ps; e.rf_we = rf;
        e.wb_sel = wb; e.b_sel = bs; e.trap = 0; e.cyc = cyc;
        return e;
    endfunction

    function automatic exp_t hlt(input logic trap, input int cyc);
        exp_t e;
        e = ret(0, 0, 0, 0, 0, cyc);
        e.halt = 1; e.trap = trap;
        return e;
    endfunction

    // memory model: inserts the requested wait states, ready otherwise
    always begin
        @(negedge clk); #1;
        if (bus.mem_req && !bus.mem_addr_sel && fwait > 0) begin
            bus.mem_ready = 1'b0; fwait--;
        end else if (bus.mem_req && bus.mem_addr_sel && mwait > 0) begin
            bus.mem_ready = 1'b0; mwait--;
        end else begin
            bus.mem_ready = 1'b1;
        end
    end

    // monitor
    int   cnt = 0;
    logic rst_prev = 1'b1, halted_prev = 1'b0, stall = 1'b0, stall_we = 1'b0, stall_as = 1'b0;
    always begin
        exp_t e;
        @(negedge clk); #2;
        if (rst) begin
            cnt = 0;
            chk("reset_outputs", int'({bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we,
                bus.pc_we, bus.pc_src, bus.rf_we, bus.wb_sel, bus.alu_a_sel, bus.alu_b_sel,
                bus.alu_mode, bus.retire, bus.halted, bus.trap_illegal}), 0);
        end else begin
            if (rst_prev) begin
                chk("restart_mem_req", int'(bus.mem_req), 1);
                chk("restart_addr_sel", int'(bus.mem_addr_sel), 0);
            end
            if (stall) begin
                chk("stall_mem_req", int'(bus.mem_req), 1);
                chk("stall_addr_sel", int'(bus.mem_addr_sel), int'(stall_as));
                chk("stall_mem_we", int'(bus.mem_we), int'(stall_we));
            end
            if (!bus.halted) cnt++;
            if (bus.retire) begin
                if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("event_is_retire", int'(e.halt), 0);
                    chk("retire_cycles", cnt, e.cyc);
                    chk("retire_pc_we", int'(bus.pc_we), int'(e.pc_we));
                    chk("retire_pc_src", int'(bus.pc_src), int'(e.pc_src));
                    chk("retire_rf_we", int'(bus.rf_we), int'(e.rf_we));
                    chk("retire_wb_sel", int'(bus.wb_sel), int'(e.wb_sel));
                    chk("retire_alu_b_sel", int'(bus.alu_b_sel), int'(e.b_sel));
                end
                cnt = 0;
                done_cnt++;
            end
            if (bus.halted && !halted_prev) begin
                if (exp_q.size() == 0) chk("unexpected_halt", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("event_is_halt", int'(e.halt), 1);
                    chk("halt_cycles", cnt, e.cyc);
                    chk("halt_trap_illegal", int'(bus.trap_illegal), int'(e.trap));
                end
                done_cnt++;
            end else if (bus.halted) begin
                chk("halt_quiet", int'({bus.mem_req, bus.mem_we, bus.pc_we, bus.rf_we,
                    bus.retire, bus.ir_we}), 0);
            end
        end
        stall       = !rst && bus.mem_req && !bus.mem_ready;
        stall_we    = bus.mem_we;
        stall_as    = bus.mem_addr_sel;
        rst_prev    = rst;
        halted_prev = bus.halted && !rst;
    end

    // present one instruction and wait for its nev scoreboard events
    task automatic run(input logic [31:0] w, input int fw, input int mw,
                       input logic tk, input int nev);
        int tgt;
        bus.instr = w; bus.branch_taken = tk; fwait = fw; mwait = mw;
        tgt = done_cnt + nev;
        for (int i = 0; i < 60; i++) begin
            if (done_cnt >= tgt) break;
            @(negedge clk);
        end
        if (done_cnt < tgt) chk("timeout_events", done_cnt, tgt);
    endtask

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] LW    = 32'h0000_A103;
    localparam logic [31:0] SW    = 32'h0020_A223;
    localparam logic [31:0] BEQ   = 32'h0020_8463;
    localparam logic [31:0] JALR  = 32'h0000_80E7;
    localparam logic [31:0] JAL   = 32'h0080_00EF;
    localparam logic [31:0] LUI   = 32'h1234_50B7;
    localparam logic [31:0] AUIPC = 32'h0000_1097;
    localparam logic [31:0] ADD   = 32'h0020_81B3;
    localparam logic [31:0] FENCE = 32'h0000_000F;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] ILL   = 32'hFFFF_FFFF;

    initial begin
        bus.instr = ADDI; bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        exp_q.push_back(ret(1, 0, 1, 0, 1, 4)); run(ADDI, 0, 0, 0, 1);
        exp_q.push_back(ret(1, 0, 1, 1, 1, 7)); run(LW, 0, 2, 0, 1);
        exp_q.push_back(ret(1, 0, 0, 0, 1, 5)); run(SW, 1, 0, 0, 1);
        exp_q.push_back(ret(1, 1, 0, 0, 0, 3)); run(BEQ, 0, 0, 1, 1);
        exp_q.push_back(ret(1, 0, 0, 0, 0, 3)); run(BEQ, 0, 0, 0, 1);
        exp_q.push_back(ret(1, 2, 1, 2, 1, 3)); run(JALR, 0, 0, 0, 1);
        exp_q.push_back(ret(1, 1, 1, 2, 0, 3)); run(JAL, 0, 0, 0, 1);
        exp_q.push_back(ret(1, 0, 1, 3, 0, 4)); run(LUI, 0, 0, 0, 1);
        exp_q.push_back(ret(1, 0, 1, 0, 1, 4)); run(AUIPC, 0, 0, 0, 1);
        exp_q.push_back(ret(1, 0, 1, 0, 0, 6)); run(ADD, 2, 0, 0, 1);
        exp_q.push_back(ret(1, 0, 0, 0, 0, 3)); run(FENCE, 0, 0, 0, 1);
        exp_q.push_back(ret(0, 0, 0, 0, 0, 3));
        exp_q.push_back(hlt(0, 0));             run(ECALL, 0, 0, 0, 2);
        repeat (4) @(negedge clk);

        rst = 1'b1; @(negedge clk); rst = 1'b0;
        exp_q.push_back(hlt(1, 3));             run(ILL, 0, 0, 0, 1);
        repeat (4) @(negedge clk);

        // reset while FETCH is stalled
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.instr = ADDI; fwait = 5;
        repeat (2) @(negedge clk);
        rst = 1'b1; fwait = 0; @(negedge clk); rst = 1'b0;
        exp_q.push_back(ret(1, 0, 1, 0, 1, 4)); run(ADDI, 0, 0, 0, 1);

        // reset during a stalled store in MEM
        bus.instr = SW; mwait = 5;
        repeat (4) @(negedge clk);
        rst = 1'b1; mwait = 0; @(negedge clk); rst = 1'b0;
        exp_q.push_back(ret(1, 0, 1, 0, 1, 4)); run(ADDI, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
